// File: rtl/dp_ram_clr.sv
// Dual-clock, dual-port RAM with byte-enabled writes, a hardware clear sweep on the
// write clock and a valid-qualified read pipeline on the read clock.
`timescale 1ns/100ps
module dp_ram_clr #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 128,
  parameter int OUT_REG = 0
) (
  input  logic              clk_wr,
  input  logic              clk_rd,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic              clr_busy,
  output logic              wr_drop,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam int NB     = DATA_W / 8;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {READY, CLEAR} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_drop_q, wr_drop_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              wr_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;

  // The sweep shares the single write port; user writes only reach it in READY.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (rst) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
      mem_we    = 1'b1;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr_q;
      mem_wdata = '0;
      mem_be    = '1;
      wr_drop_d = wr_en;
      if (clr_ptr_q == LAST) state_d = READY;
      else                   clr_ptr_d = clr_ptr_q + 1'b1;
    end else begin
      if (clr_req) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
      wr_drop_d = wr_en & (clr_req | ~wr_in_range);
      mem_we    = wr_en & ~clr_req & wr_in_range;
    end
  end

  always_ff @(posedge clk_wr) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    wr_drop_q <= wr_drop_d;
  end

  always_ff @(posedge clk_wr) begin
    if (mem_we)
      for (int k = 0; k < NB; k++)
        if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
  end

  assign clr_busy = (state_q == CLEAR);
  assign wr_drop  = wr_drop_q;

  // ---------------- read domain ----------------
  logic rst_meta_q, rst_rd_q;

  always_ff @(posedge clk_rd) begin
    rst_meta_q <= rst;
    rst_rd_q   <= rst_meta_q;
  end

  logic [STAGES:1]             vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][DATA_W-1:0] dat_pipe_q, dat_pipe_d;
  logic [DATA_W-1:0]           rd_word;

  assign rd_word = ({1'b0, rd_addr} < DEPTH_V) ? mem[rd_addr] : '0;

  // Data stages only advance with their valid bit so rd_data holds between reads.
  always_comb begin
    vld_pipe_d = '0;
    dat_pipe_d = dat_pipe_q;
    if (rst_rd_q) begin
      dat_pipe_d = '0;
    end else begin
      vld_pipe_d[1] = rd_en;
      if (rd_en) dat_pipe_d[1] = rd_word;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_d[s] = dat_pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_rd) begin
    vld_pipe_q <= vld_pipe_d;
    dat_pipe_q <= dat_pipe_d;
  end

  assign rd_data  = dat_pipe_q[STAGES];
  assign rd_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_dp_ram_clr.sv
// Directed bench for dp_ram_clr: one instance without and one with the output
// register, sharing stimulus, checked against hand-computed values and a scoreboard.
`timescale 1ns/100ps
module tb_dp_ram_clr;
  logic        clk_wr, clk_rd, rst, clr_req, wr_en, rd_en;
  logic [6:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        busy0, busy1, drop0, drop1, rv0, rv1;
  logic [15:0] rd0, rd1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb [100];

  dp_ram_clr #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .OUT_REG(0)) u_dut0 (
    .clk_wr(clk_wr), .clk_rd(clk_rd), .rst(rst), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_busy(busy0), .wr_drop(drop0),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0));

  dp_ram_clr #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .OUT_REG(1)) u_dut1 (
    .clk_wr(clk_wr), .clk_rd(clk_rd), .rst(rst), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_busy(busy1), .wr_drop(drop1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1));

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;
  initial clk_rd = 1'b0;
  always #13.5 clk_rd = ~clk_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic en, input logic [6:0] a, input logic [15:0] d,
                    input logic [1:0] be, input logic cr);
    @(negedge clk_wr);
    wr_en = en; wr_addr = a; wr_data = d; wr_be = be; clr_req = cr;
    @(posedge clk_wr);
    #1;
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  // Counts clk_wr edges until clr_busy falls, bounded.
  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(posedge clk_wr);
      n++;
      #1;
    end while ((busy0 || busy1) && n < 300);
  endtask

  task automatic rd_check(input logic [6:0] a, input logic [15:0] e);
    @(negedge clk_rd);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk_rd);
    #1;
    rd_en = 1'b0;
    chk($sformatf("rd_lat1[%0d]", a), {15'd0, rv0, rd0}, {15'd0, 1'b1, e});
    chk($sformatf("rd_lat2_early[%0d]", a), {31'd0, rv1}, 32'd0);
    @(posedge clk_rd);
    #1;
    chk($sformatf("rd_pulse[%0d]", a), {31'd0, rv0}, 32'd0);
    chk($sformatf("rd_lat2[%0d]", a), {15'd0, rv1, rd1}, {15'd0, 1'b1, e});
  endtask

  typedef struct {
    logic [6:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        drop;
    logic [6:0]  ra;
    logic [15:0] rexp;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int n;
    tbl[0] = '{7'd5,   16'hABCD, 2'b11, 1'b0, 7'd5,   16'hABCD};
    tbl[1] = '{7'd5,   16'h1234, 2'b01, 1'b0, 7'd5,   16'hAB34};
    tbl[2] = '{7'd5,   16'hFFFF, 2'b00, 1'b0, 7'd5,   16'hAB34};
    tbl[3] = '{7'd5,   16'h5678, 2'b10, 1'b0, 7'd5,   16'h5634};
    tbl[4] = '{7'd120, 16'hDEAD, 2'b11, 1'b1, 7'd5,   16'h5634};
    tbl[5] = '{7'd99,  16'hBEEF, 2'b11, 1'b0, 7'd99,  16'hBEEF};
    tbl[6] = '{7'd100, 16'h1111, 2'b11, 1'b1, 7'd100, 16'h0000};
    tbl[7] = '{7'd0,   16'h0F0F, 2'b11, 1'b0, 7'd0,   16'h0F0F};
    tbl[8] = '{7'd127, 16'h2222, 2'b11, 1'b1, 7'd110, 16'h0000};
    tbl[9] = '{7'd98,  16'hCAFE, 2'b11, 1'b0, 7'd99,  16'hBEEF};

    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_be = '0; rd_en = 1'b0; rd_addr = '0;

    // Reset and initial clear
    repeat (3) @(posedge clk_wr);
    #1;
    chk("rst_busy", {30'd0, busy1, busy0}, 32'd3);
    chk("rst_drop", {30'd0, drop1, drop0}, 32'd0);
    @(negedge clk_wr);
    rst = 1'b0;
    count_busy(n);
    chk("rst_clear_edges", n, 100);
    chk("rst_rd_side", {rv1, rv0, rd1, rd0}, 34'd0);
    repeat (2) @(posedge clk_rd);
    for (int a = 0; a < 100; a++) rd_check(7'(a), 16'h0000);

    // Table: byte enables, range drops, single-cycle drop pulse
    for (int i = 0; i < 10; i++) begin
      wr(1'b1, tbl[i].wa, tbl[i].wd, tbl[i].be, 1'b0);
      chk($sformatf("tbl%0d_drop", i), {30'd0, drop1, drop0}, {30'd0, tbl[i].drop, tbl[i].drop});
      @(posedge clk_wr);
      #1;
      chk($sformatf("tbl%0d_drop_end", i), {30'd0, drop1, drop0}, 32'd0);
      repeat (2) @(posedge clk_rd);
      rd_check(tbl[i].ra, tbl[i].rexp);
    end

    // Soft clear with a colliding write, then a write during the sweep
    for (int a = 0; a < 100; a++) wr(1'b1, 7'(a), 16'(a + 1), 2'b11, 1'b0);
    repeat (2) @(posedge clk_rd);
    rd_check(7'd42, 16'd43);
    rd_check(7'd99, 16'd100);
    wr(1'b1, 7'd3, 16'h7777, 2'b11, 1'b1);
    chk("soft_req_drop", {30'd0, drop1, drop0}, 32'd3);
    chk("soft_busy", {30'd0, busy1, busy0}, 32'd3);
    wr(1'b1, 7'd7, 16'h8888, 2'b11, 1'b0);
    chk("clear_wr_drop", {30'd0, drop1, drop0}, 32'd3);
    count_busy(n);
    chk("soft_clear_edges", n + 1, 100);
    repeat (2) @(posedge clk_rd);
    for (int a = 0; a < 100; a++) rd_check(7'(a), 16'h0000);

    // Reset at clr_ptr=40 restarts the sweep; read side ignores rd_en meanwhile
    for (int a = 50; a < 60; a++) wr(1'b1, 7'(a), 16'hA500 + 16'(a), 2'b11, 1'b0);
    wr(1'b0, 7'd0, 16'd0, 2'b00, 1'b1);
    repeat (40) @(posedge clk_wr);
    #1;
    chk("mid_busy", {30'd0, busy1, busy0}, 32'd3);
    @(negedge clk_wr);
    rst = 1'b1;
    repeat (4) @(posedge clk_rd);
    @(negedge clk_rd);
    rd_en = 1'b1; rd_addr = 7'd55;
    @(posedge clk_rd);
    #1;
    rd_en = 1'b0;
    chk("rdrst_lat1", {15'd0, rv0, rd0}, 32'd0);
    @(posedge clk_rd);
    #1;
    chk("rdrst_lat2", {15'd0, rv1, rd1}, 32'd0);
    chk("mid_rst_busy", {30'd0, busy1, busy0}, 32'd3);
    @(negedge clk_wr);
    rst = 1'b0;
    count_busy(n);
    chk("mid_clear_edges", n, 100);
    repeat (4) @(posedge clk_rd);
    for (int a = 50; a < 60; a++) rd_check(7'(a), 16'h0000);

    // Cross-clock stress: writer on 0..49, reader on 50..99
    for (int a = 0; a < 100; a++) sb[a] = 16'h0000;
    for (int a = 50; a < 100; a++) begin
      logic [15:0] d;
      d = 16'($urandom);
      wr(1'b1, 7'(a), d, 2'b11, 1'b0);
      sb[a] = d;
    end
    repeat (2) @(posedge clk_rd);
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [6:0]  a;
          logic [15:0] d;
          logic [1:0]  be;
          a  = 7'($urandom_range(0, 49));
          d  = 16'($urandom);
          be = 2'($urandom);
          wr(1'b1, a, d, be, 1'b0);
          for (int k = 0; k < 2; k++) if (be[k]) sb[a][8*k +: 8] = d[8*k +: 8];
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          logic [6:0] a;
          a = 7'($urandom_range(50, 99));
          rd_check(a, sb[a]);
        end
      end
    join
    repeat (2) @(posedge clk_rd);
    for (int a = 0; a < 50; a++) rd_check(7'(a), sb[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dp_ram_clr.md
# dp_ram_clr

Parametrised dual-clock, dual-port RAM: the next generation of the team's 8-bit asynchronous RAM, with independent read/write addresses, byte-enabled writes, a hardware clear sequencer and a valid-qualified read pipeline. The write port and clear FSM run on `clk_wr`; the read port runs on `clk_rd`. It serves as the shared storage block between producer and consumer logic in unrelated clock domains.

## Interface
Parameters:
- `DATA_W`, default 8: data width; must be a multiple of 8.
- `ADDR_W`, default 7: address width.
- `DEPTH`, default 128: number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.
- `OUT_REG`, default 0: 1 adds an output register stage on the read side.

Ports:
- `clk_wr`  in  1  write clock; also clocks the clear FSM.
- `clk_rd`  in  1  read clock.
- `rst`  in  1  reset: synchronous to `clk_wr`, active-high; clears all memory contents.
- `clr_req`  in  1  single-cycle request (clk_wr) to clear memory without reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_be`  in  DATA_W/8  byte enables; bit k enables `wr_data[8k+7:8k]`.
- `clr_busy`  out  1  high while the clear sequencer owns the write port.
- `wr_drop`  out  1  one-cycle pulse: the previous `wr_en` was discarded.
- `rd_en`  in  1  read strobe (clk_rd).
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse (clk_rd) qualifying `rd_data`.

## Operation
- Storage: DEPTH × DATA_W array, no reset on the array itself; cleared only by the sequencer.
- Clear FSM (clk_wr), states READY and CLEAR, with a clear pointer `clr_ptr` of ADDR_W bits:
  - `rst`=1 → CLEAR, `clr_ptr`=0, `clr_busy`=1. While `rst` stays high, word 0 is written with 0 and the pointer holds.
  - CLEAR with `rst`=0: write 0 to `clr_ptr` and increment. After writing DEPTH-1 → READY, `clr_busy`=0.
  - READY and `clr_req`=1 → CLEAR with `clr_ptr`=0.
  - `clr_req` during CLEAR is ignored. `rst` during CLEAR restarts the pointer at 0.
- Write (READY only): when `wr_en`=1 and `wr_addr`<DEPTH, write the bytes enabled by `wr_be`; disabled bytes keep their old value.
  - `wr_en` with `wr_be`=0 is a legal no-op and is not a drop.
- Drop: when `wr_en`=1 and (state is CLEAR, or `wr_addr`≥DEPTH, or `clr_req`=1 in the same cycle), the write is discarded and `wr_drop` pulses on the next cycle.
- Read: when `rd_en`=1 the block samples `rd_addr`. If `rd_addr`≥DEPTH, `rd_data` returns 0.
- Read-side reset: `rst` passes through a 2-flop synchroniser into clk_rd. While the synchronised reset is high, `rd_data`=0, `rd_valid`=0 and `rd_en` is ignored.
- Reads during CLEAR are permitted; they return old data or 0 depending on sweep progress.
- Same-address write/read collision in the same window: the read returns either the old or the new word. The array is never corrupted.

## Timing
- Reset values: `clr_busy`=1 (CLEAR state), `wr_drop`=0, `rd_data`=0, `rd_valid`=0.
- Clear duration: `clr_busy` falls after the DEPTH-th `clk_wr` edge with `rst`=0 (or after the `clr_req` edge). The first accepted write lands on the following edge.
- Write latency: 1 `clk_wr` edge. The data is visible to a read beginning 2 `clk_rd` edges after that write edge, or later.
- Read latency: `rd_data`/`rd_valid` update on edge 1 after the `rd_en` edge when OUT_REG=0, and on edge 2 when OUT_REG=1. Back-to-back reads are allowed at full rate.
- Read-side reset lag: asserts 2–3 `clk_rd` edges after `rst` is sampled high, and releases 2–3 edges after `rst` is sampled low.
- `wr_drop`: asserted for exactly one `clk_wr` cycle, on the cycle after the dropped strobe.

## Test plan
Bench configuration: DATA_W=16, ADDR_W=7, DEPTH=100.
- Reset and clear: hold `rst` 3 cycles, then release → `clr_busy` stays 1 for exactly 100 `clk_wr` edges; reading addresses 0..99 afterwards returns 0x0000 each with one `rd_valid` pulse, latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- Byte enable: write 0xABCD to addr 5 with `wr_be`=11, then 0x1234 with `wr_be`=01 → reading addr 5 returns 0xAB34.
- Drops: `wr_en` to addr 120 → `wr_drop`=1 for one cycle and memory is unchanged; `wr_en` during CLEAR → drop; reading addr 110 → `rd_data`=0x0000 with `rd_valid`=1.
- Soft clear: fill addrs 0..99 with the value addr+1, pulse `clr_req` together with a write → that write drops, `clr_busy` is high 100 cycles, and all reads return 0.
- Reset mid-clear: assert `rst` at `clr_ptr`=40 → the sweep restarts at 0 and `clr_busy` falls 100 edges after `rst` release.
- Cross-clock stress: `clk_wr`=100 MHz and `clk_rd`=37 MHz, with random writes and reads to distinct addresses → every read matches the scoreboard, and no reads occur while the synchronised reset is active.
